// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer constants, colour type, source-select width and draw-FSM states shared by write sources
package fb_pkg;
  localparam int FB_SCREEN_W = 640;
  localparam int FB_SCREEN_H = 480;
  localparam int FB_COLOR_DEPTH = 9;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb333_t;
  typedef enum logic [2:0] {IDLE, UPDATE, WAIT_SEL, DRAW, DONE} draw_state_t;
  function automatic int sel_width(input int max_src);
    return max_src < 1 ? 1 : $clog2(max_src + 1);
  endfunction
endpackage

// File: rtl/tilt_pos_clamp.sv
// tilt_pos_clamp: one-axis position step by a tilt amount, clamped to [0, MAX_POS]
// ports: pos (current), amount/dir (tilt step, dir=1 adds), new_pos (clamped result)
module tilt_pos_clamp #(
  parameter int MAX_POS = 608
) (
  input  logic [11:0] pos,
  input  logic [3:0]  amount,
  input  logic        dir,
  output logic [11:0] new_pos
);
  localparam logic signed [11:0] LIM = 12'(MAX_POS);
  logic signed [11:0] sum;
  assign sum = dir ? $signed(pos + {8'd0, amount}) : $signed(pos - {8'd0, amount});
  assign new_pos = sum[11] ? '0 : (sum > LIM) ? LIM : sum;
endmodule

// File: rtl/tilt_box_draw.sv
// tilt_box_draw: once per frame, raster-draws a bordered box at a tilt-driven position into the shared frame-buffer write port
// ports: clk/resetN (sync active-low), frame pulse, tilt_* (per-axis step and direction),
//        write_source_sel/write_awaited (grant and beat accept), write_* (shared bus, 'z when not selected)
module tilt_box_draw
  import fb_pkg::*;
#(
  parameter int SOURCE_ID = 2,
  parameter int MAX_WRITE_SOURCE = 2,
  parameter int COLOR_DEPTH = FB_COLOR_DEPTH,
  parameter int SCREEN_W = FB_SCREEN_W,
  parameter int SCREEN_H = FB_SCREEN_H,
  parameter int BOX_W = 32,
  parameter int BOX_H = 24,
  parameter int INIT_X = 304,
  parameter int INIT_Y = 228,
  parameter logic [COLOR_DEPTH-1:0] BORDER_COLOR = 9'b111111000,
  parameter logic [COLOR_DEPTH-1:0] FILL_COLOR = 9'b000000111,
  parameter bit HOLLOW = 1'b0
) (
  input  logic                                     clk,
  input  logic                                     resetN,
  input  logic                                     frame,
  input  logic [3:0]                               tilt_amount_x,
  input  logic                                     tilt_direction_x,
  input  logic [3:0]                               tilt_amount_y,
  input  logic                                     tilt_direction_y,
  input  logic [sel_width(MAX_WRITE_SOURCE)-1:0]   write_source_sel,
  input  logic                                     write_awaited,
  output logic                                     write_active,
  output logic [31:0]                              write_x_addr,
  output logic [31:0]                              write_y_addr,
  output logic [COLOR_DEPTH-1:0]                   write_color_data,
  output logic                                     write_transparent
);
  localparam int SEL_W = sel_width(MAX_WRITE_SOURCE);
  localparam int CW = $clog2(BOX_W);
  localparam int RW = $clog2(BOX_H);
  draw_state_t state;
  logic [11:0] pos_x, pos_y, new_x, new_y, px_x, px_y, x_r, y_r;
  logic [CW-1:0] col, ld_col;
  logic [RW-1:0] row, ld_row;
  logic [COLOR_DEPTH-1:0] color_r;
  logic pending, active, tr_r, sel_hit, accept, last_col, last_px, border, step;
  tilt_pos_clamp #(.MAX_POS(SCREEN_W - BOX_W)) u_clamp_x (
    .pos(pos_x), .amount(tilt_amount_x), .dir(tilt_direction_x), .new_pos(new_x)
  );
  tilt_pos_clamp #(.MAX_POS(SCREEN_H - BOX_H)) u_clamp_y (
    .pos(pos_y), .amount(tilt_amount_y), .dir(tilt_direction_y), .new_pos(new_y)
  );
  assign sel_hit = write_source_sel == SEL_W'(SOURCE_ID);
  assign accept = sel_hit && write_awaited && active;
  assign last_col = col == CW'(BOX_W - 1);
  assign last_px = last_col && row == RW'(BOX_H - 1);
  // next pixel to present: origin when a draw starts, raster successor while drawing
  assign ld_col = (state == DRAW && !last_col) ? col + 1'b1 : '0;
  assign ld_row = (state != DRAW) ? '0 : last_col ? row + 1'b1 : row;
  assign border = ld_col == '0 || ld_col == CW'(BOX_W - 1) || ld_row == '0 || ld_row == RW'(BOX_H - 1);
  assign px_x = pos_x + 12'(ld_col);
  assign px_y = pos_y + 12'(ld_row);
  assign step = (state == WAIT_SEL && sel_hit) || (accept && !last_px);
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
      pos_x <= 12'(INIT_X);
      pos_y <= 12'(INIT_Y);
      pending <= 1'b0;
      col <= '0;
      row <= '0;
      active <= 1'b0;
      x_r <= '0;
      y_r <= '0;
      color_r <= '0;
      tr_r <= 1'b0;
    end else begin
      if (frame && state != IDLE) pending <= 1'b1;
      if (step) begin
        col <= ld_col;
        row <= ld_row;
        x_r <= px_x;
        y_r <= px_y;
        color_r <= border ? BORDER_COLOR : FILL_COLOR;
        tr_r <= border ? 1'b0 : HOLLOW;
      end
      case (state)
        IDLE: if (frame) state <= UPDATE;
        UPDATE: begin
          pos_x <= new_x;
          pos_y <= new_y;
          state <= WAIT_SEL;
        end
        WAIT_SEL: if (sel_hit) begin
          state <= DRAW;
          active <= 1'b1;
        end
        DRAW: if (accept && last_px) begin
          state <= DONE;
          active <= 1'b0;
        end
        // a frame arriving in this very cycle must not be lost on the way back to IDLE
        DONE: begin
          state <= (pending || frame) ? UPDATE : IDLE;
          pending <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign write_active = sel_hit ? active : 1'bz;
  assign write_x_addr = sel_hit ? (active ? {20'd0, x_r} : '0) : 'z;
  assign write_y_addr = sel_hit ? (active ? {20'd0, y_r} : '0) : 'z;
  assign write_color_data = sel_hit ? (active ? color_r : '0) : 'z;
  assign write_transparent = sel_hit ? (active & tr_r) : 1'bz;
endmodule

// File: tb/tb_tilt_box_draw.sv
// tb_tilt_box_draw: randomized and directed stimulus for tilt_box_draw against a pixel-list reference model
module tb_tilt_box_draw;
  localparam logic [8:0] BORDER = 9'b111111000;
  localparam logic [8:0] FILL = 9'b000000111;
  localparam bit HOLLOW = 1'b0;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic frame = 1'b0;
  logic write_awaited = 1'b1;
  logic [3:0] tilt_amount_x = '0;
  logic [3:0] tilt_amount_y = '0;
  logic tilt_direction_x = 1'b1;
  logic tilt_direction_y = 1'b1;
  logic [1:0] write_source_sel = 2'd2;
  wire write_active, write_transparent;
  wire [31:0] write_x_addr, write_y_addr;
  wire [8:0] write_color_data;
  wire [79:0] obs = {6'd0, write_x_addr, write_y_addr, write_color_data, write_transparent};
  typedef struct {
    logic [79:0] px;
    bit last;
  } beat_t;
  beat_t q[$];
  int n_pass = 0, n_checks = 0, beats = 0, px_m = 304, py_m = 228;
  bit mon_en = 1'b0, expect_drop = 1'b0;

  tilt_box_draw dut (
    .clk(clk), .resetN(resetN), .frame(frame),
    .tilt_amount_x(tilt_amount_x), .tilt_direction_x(tilt_direction_x),
    .tilt_amount_y(tilt_amount_y), .tilt_direction_y(tilt_direction_y),
    .write_source_sel(write_source_sel), .write_awaited(write_awaited),
    .write_active(write_active), .write_x_addr(write_x_addr), .write_y_addr(write_y_addr),
    .write_color_data(write_color_data), .write_transparent(write_transparent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic int clamp_step(int p, int a, bit d, int mx);
    int v = d ? p + a : p - a;
    return v < 0 ? 0 : v > mx ? mx : v;
  endfunction

  function automatic logic [79:0] pix(int x, int y, bit b);
    return {6'd0, 32'(x), 32'(y), b ? BORDER : FILL, b ? 1'b0 : HOLLOW};
  endfunction

  task automatic push_frame();
    px_m = clamp_step(px_m, int'(tilt_amount_x), tilt_direction_x, 640 - 32);
    py_m = clamp_step(py_m, int'(tilt_amount_y), tilt_direction_y, 480 - 24);
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 32; c++)
        q.push_back('{pix(px_m + c, py_m + r, c == 0 || c == 31 || r == 0 || r == 23), r == 23 && c == 31});
  endtask

  always @(negedge clk) if (mon_en) begin
    if (write_source_sel == 2'd2) begin
      if (expect_drop) begin
        check("drop", write_active, 0);
        expect_drop = 1'b0;
      end else if (write_active === 1'b1) begin
        if (q.size() == 0) check("extra_beat", 1, 0);
        else begin
          check("pixel", obs, q[0].px);
          if (write_awaited) begin
            expect_drop = q[0].last;
            void'(q.pop_front());
            beats++;
          end
        end
      end else check("idle_bus", obs, 0);
    end else begin
      check("gap_active", write_active === 1'b1, 0);
      expect_drop = 1'b0;
    end
  end

  task automatic frame_start();
    @(posedge clk);
    #2;
    frame = 1'b1;
    push_frame();
  endtask

  // mode 0: always accept, 1: toggled accept, 2: random accept and random grant loss
  task automatic run(input int mode, input int gap_at, input int dbl_at, input int rst_at);
    int cyc = 0, gap_left = 0, dbl_ph = 0, b0 = beats;
    bit gap_done = 1'b0, rst_done = 1'b0;
    while ((q.size() > 0 || expect_drop) && cyc < 6000) begin
      @(posedge clk);
      #2;
      cyc++;
      frame = 1'b0;
      write_awaited = mode == 1 ? ~write_awaited : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (gap_at >= 0 && !gap_done && beats - b0 == gap_at) begin
        gap_left = 50;
        gap_done = 1'b1;
      end
      write_source_sel = (gap_left > 0 || (mode == 2 && $urandom_range(0, 3) == 0)) ? 2'd1 : 2'd2;
      if (gap_left > 0) gap_left--;
      if (dbl_at >= 0 && dbl_ph < 4 && beats - b0 >= dbl_at) begin
        frame = dbl_ph == 0 || dbl_ph == 2;
        dbl_ph++;
        if (dbl_ph == 4) push_frame();
      end
      if (rst_at >= 0 && !rst_done && beats - b0 >= rst_at) begin
        rst_done = 1'b1;
        resetN = 1'b0;
        @(posedge clk);
        #2;
        resetN = 1'b1;
        q.delete();
        expect_drop = 1'b0;
        px_m = 304;
        py_m = 228;
        check("rst_active", write_active, 0);
        check("rst_bus", obs, 0);
      end
    end
    check("drain", q.size() == 0 && !expect_drop, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired n_pass=%0d n_checks=%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("reset_active", write_active, 0);
    check("reset_bus", obs, 0);
    resetN = 1'b1;
    mon_en = 1'b1;
    frame_start();
    @(posedge clk);
    #2;
    frame = 1'b0;
    check("lat_update", write_active, 0);
    @(posedge clk);
    #2;
    check("lat_wait", write_active, 0);
    @(posedge clk);
    #2;
    check("lat_draw", write_active, 1);
    check("first_px", obs, {6'd0, 32'd304, 32'd228, BORDER, 1'b0});
    run(0, -1, -1, -1);
    frame_start();
    run(1, -1, -1, -1);
    frame_start();
    run(0, 100, -1, -1);
    tilt_amount_x = 4'd15;
    tilt_direction_x = 1'b1;
    tilt_amount_y = 4'd15;
    tilt_direction_y = 1'b0;
    for (int i = 0; i < 25; i++) begin
      frame_start();
      run(0, -1, -1, -1);
    end
    tilt_amount_x = 4'd3;
    tilt_direction_x = 1'b0;
    tilt_amount_y = 4'd2;
    tilt_direction_y = 1'b1;
    frame_start();
    run(0, -1, 300, -1);
    for (int i = 0; i < 6; i++) begin
      tilt_amount_x = 4'($urandom_range(0, 15));
      tilt_direction_x = 1'($urandom_range(0, 1));
      tilt_amount_y = 4'($urandom_range(0, 15));
      tilt_direction_y = 1'($urandom_range(0, 1));
      frame_start();
      run(2, -1, -1, -1);
    end
    frame_start();
    run(0, -1, -1, 200);
    tilt_amount_x = '0;
    tilt_amount_y = '0;
    frame_start();
    run(0, -1, -1, -1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
